// File: rtl/r5p_pkg.sv
`default_nettype none
// ============================================================================
// Module      : r5p_pkg
// Description : Shared types for the r5p write-back stage: requester select
//               and the GPR write-port bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package r5p_pkg;

  // Widest GPR address / XLEN the write-port bundle can carry; narrower
  // instances zero-extend into it and truncate back out.
  localparam int unsigned AW_MAX = 5;
  localparam int unsigned XW_MAX = 64;

  // Which requester owns the write port (also the last-grant encoding).
  typedef enum logic {
    EXE = 1'b0,
    LSU = 1'b1
  } req_sel_t;

  // One GPR write: enable, destination register, data.
  typedef struct packed {
    logic              en;
    logic [AW_MAX-1:0] addr;
    logic [XW_MAX-1:0] data;
  } wr_port_t;

endpackage
`default_nettype wire

// File: rtl/r5p_gpr_sb.sv
`default_nettype none
// ============================================================================
// Module      : r5p_gpr_sb
// Description : GPR scoreboard of outstanding loads. One bit per register,
//               x0 hard-wired clear, one set port, one clear port, three
//               lookup ports. Set wins over a same-cycle clear.
// Revision    : 1.0 - initial release
// ============================================================================
module r5p_gpr_sb #(
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [AW-1:0] set_a,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_a,
  input  logic [AW-1:0] rd0_a,
  input  logic [AW-1:0] rd1_a,
  input  logic [AW-1:0] rd2_a,
  output logic          rd0_hit,
  output logic          rd1_hit,
  output logic          rd2_hit
);

  localparam int unsigned N = 2**AW;

  // Only x1..xN-1 have storage; x0 reads back as a constant zero.
  logic [N-1:1] sb_q;
  logic [N-1:1] sb_d;
  logic [N-1:0] sb_vec;

  assign sb_vec = {sb_q, 1'b0};

  // Per-bit next state: a new load to a register outranks a returning one.
  always_comb begin
    sb_d = sb_q;
    for (int i = 1; i < int'(N); i++) begin
      sb_d[i] = (set_en && (set_a == AW'(i))) ||
                (sb_q[i] && !(clr_en && (clr_a == AW'(i))));
    end
  end

  // Scoreboard storage, wiped by reset so outstanding loads are forgotten.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  assign rd0_hit = sb_vec[rd0_a];
  assign rd1_hit = sb_vec[rd1_a];
  assign rd2_hit = sb_vec[rd2_a];

  // Issuing a second load to a register that already has one in flight
  // means the issue logic lost track of a hazard.
  a_no_double_issue : assert property (
    @(posedge clk) disable iff (!rst) set_en |-> !sb_vec[set_a]
  );

endmodule
`default_nettype wire

// File: rtl/r5p_wbu.sv
`default_nettype none
// ============================================================================
// Module      : r5p_wbu
// Description : Write-back unit. Round-robin arbitration between the execute
//               unit and load data for a single registered GPR write port,
//               with a load scoreboard providing WAW blocking and read-hazard
//               flags for decode.
// Revision    : 1.0 - initial release
// ============================================================================
module r5p_wbu
  import r5p_pkg::*;
#(
  parameter int unsigned AW = 5,
  parameter int unsigned XW = 32
) (
  input  logic          clk,
  input  logic          rst,
  // execute-unit write-back request
  input  logic          exe_vld,
  output logic          exe_rdy,
  input  logic [AW-1:0] exe_a_rd,
  input  logic [XW-1:0] exe_d_rd,
  // load issue
  input  logic          lsu_iss,
  input  logic [AW-1:0] lsu_iss_a_rd,
  // load-data write-back request
  input  logic          lsu_vld,
  output logic          lsu_rdy,
  input  logic [AW-1:0] lsu_a_rd,
  input  logic [XW-1:0] lsu_d_rd,
  // GPR write port
  output logic          e_rd,
  output logic [AW-1:0] a_rd,
  output logic [XW-1:0] d_rd,
  // decode read hazards
  input  logic [AW-1:0] a_rs1,
  input  logic [AW-1:0] a_rs2,
  output logic          hz_rs1,
  output logic          hz_rs2
);

  req_sel_t last_q;
  req_sel_t last_d;
  wr_port_t wr_q;
  wr_port_t wr_d;

  logic exe_hit;
  logic rs1_hit;
  logic rs2_hit;
  logic exe_elig;
  logic lsu_elig;
  logic exe_xfer;
  logic lsu_xfer;
  logic sb_set;

  // A load to x0 has nothing to track.
  assign sb_set = lsu_iss && (lsu_iss_a_rd != '0);

  r5p_gpr_sb #(
    .AW (AW)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (sb_set),
    .set_a   (lsu_iss_a_rd),
    .clr_en  (lsu_xfer),
    .clr_a   (lsu_a_rd),
    .rd0_a   (exe_a_rd),
    .rd1_a   (a_rs1),
    .rd2_a   (a_rs2),
    .rd0_hit (exe_hit),
    .rd1_hit (rs1_hit),
    .rd2_hit (rs2_hit)
  );

  // Arbitration: exe is held off while its destination awaits load data;
  // on contention the requester not granted last time wins.
  always_comb begin
    exe_elig = exe_vld && !exe_hit;
    lsu_elig = lsu_vld;
    exe_rdy  = 1'b0;
    lsu_rdy  = 1'b0;
    if (rst) begin
      exe_rdy = exe_elig && (!lsu_elig || (last_q == LSU));
      lsu_rdy = lsu_elig && (!exe_elig || (last_q == EXE));
    end
    exe_xfer = exe_vld && exe_rdy;
    lsu_xfer = lsu_vld && lsu_rdy;
  end

  // Next write-port and last-grant state; address/data hold when idle.
  always_comb begin
    last_d    = last_q;
    wr_d      = wr_q;
    wr_d.en   = 1'b0;
    if (exe_xfer) begin
      last_d    = EXE;
      wr_d.en   = (exe_a_rd != '0);
      wr_d.addr = AW_MAX'(exe_a_rd);
      wr_d.data = XW_MAX'(exe_d_rd);
    end else if (lsu_xfer) begin
      last_d    = LSU;
      wr_d.en   = (lsu_a_rd != '0);
      wr_d.addr = AW_MAX'(lsu_a_rd);
      wr_d.data = XW_MAX'(lsu_d_rd);
    end
  end

  // Write stage and last-grant register; reset favours exe on first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q <= LSU;
      wr_q   <= '0;
    end else begin
      last_q <= last_d;
      wr_q   <= wr_d;
    end
  end

  assign e_rd = wr_q.en;
  assign a_rd = AW'(wr_q.addr);
  assign d_rd = XW'(wr_q.data);

  // A source is hazardous while its load is outstanding or while its value
  // sits in the write stage not yet committed to the register file.
  assign hz_rs1 = (a_rs1 != '0) && (rs1_hit || (e_rd && (a_rd == a_rs1)));
  assign hz_rs2 = (a_rs2 != '0) && (rs2_hit || (e_rd && (a_rd == a_rs2)));

endmodule
`default_nettype wire

// File: tb/tb_r5p_wbu.sv
`default_nettype none
// ============================================================================
// Module      : tb_r5p_wbu
// Description : Self-checking bench for r5p_wbu: directed scenarios followed
//               by random traffic against a behavioural model; GPR writes are
//               checked by a scoreboard queue drained by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_r5p_wbu;

  localparam int AW = 5;
  localparam int XW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          exe_vld = 1'b0;
  logic          exe_rdy;
  logic [AW-1:0] exe_a_rd = '0;
  logic [XW-1:0] exe_d_rd = '0;
  logic          lsu_iss = 1'b0;
  logic [AW-1:0] lsu_iss_a_rd = '0;
  logic          lsu_vld = 1'b0;
  logic          lsu_rdy;
  logic [AW-1:0] lsu_a_rd = '0;
  logic [XW-1:0] lsu_d_rd = '0;
  logic          e_rd;
  logic [AW-1:0] a_rd;
  logic [XW-1:0] d_rd;
  logic [AW-1:0] a_rs1 = '0;
  logic [AW-1:0] a_rs2 = '0;
  logic          hz_rs1;
  logic          hz_rs2;

  r5p_wbu #(.AW(AW), .XW(XW)) dut (
    .clk          (clk),
    .rst          (rst),
    .exe_vld      (exe_vld),
    .exe_rdy      (exe_rdy),
    .exe_a_rd     (exe_a_rd),
    .exe_d_rd     (exe_d_rd),
    .lsu_iss      (lsu_iss),
    .lsu_iss_a_rd (lsu_iss_a_rd),
    .lsu_vld      (lsu_vld),
    .lsu_rdy      (lsu_rdy),
    .lsu_a_rd     (lsu_a_rd),
    .lsu_d_rd     (lsu_d_rd),
    .e_rd         (e_rd),
    .a_rd         (a_rd),
    .d_rd         (d_rd),
    .a_rs1        (a_rs1),
    .a_rs2        (a_rs2),
    .hz_rs1       (hz_rs1),
    .hz_rs2       (hz_rs2)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int unsigned a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];

  // Reference model: which registers await load data, who was granted last,
  // and which register sits in the write stage right now.
  bit          busy[32];
  bit          last_was_lsu;
  bit          pend_en;
  int unsigned pend_a;
  bit          got_exe;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit hz_model(input int unsigned a);
    return (a != 0) && (busy[a] || (pend_en && (pend_a == a)));
  endfunction

  task automatic model_reset();
    foreach (busy[i]) busy[i] = 1'b0;
    last_was_lsu = 1'b1;
    pend_en      = 1'b0;
    pend_a       = 0;
    exp_q.delete();
  endtask

  // Called at posedge+1; holds reset for one edge, releases at posedge+1.
  task automatic do_reset(input bit ev, input bit lv, input int unsigned probe);
    rst          = 1'b0;
    exe_vld      = ev;
    exe_a_rd     = 5'd3;
    lsu_vld      = lv;
    lsu_a_rd     = 5'd4;
    lsu_iss      = 1'b0;
    a_rs1        = AW'(probe);
    a_rs2        = AW'(probe);
    #1;
    chk("rst_e_rd", e_rd, 0);
    chk("rst_a_rd", a_rd, 0);
    chk("rst_d_rd", d_rd, 0);
    chk("rst_exe_rdy", exe_rdy, 0);
    chk("rst_lsu_rdy", lsu_rdy, 0);
    chk("rst_hz_rs1", hz_rs1, 0);
    chk("rst_hz_rs2", hz_rs2, 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold_e_rd", e_rd, 0);
    rst = 1'b1;
  endtask

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic step(input bit ev, input int unsigned ea, input logic [31:0] ed,
                      input bit iss, input int unsigned ia,
                      input bit lv, input int unsigned la, input logic [31:0] ld,
                      input int unsigned r1, input int unsigned r2);
    bit  exe_ok;
    bit  g_exe;
    bit  g_lsu;
    wr_t w;
    exe_vld      = ev;
    exe_a_rd     = AW'(ea);
    exe_d_rd     = ed;
    lsu_iss      = iss;
    lsu_iss_a_rd = AW'(ia);
    lsu_vld      = lv;
    lsu_a_rd     = AW'(la);
    lsu_d_rd     = ld;
    a_rs1        = AW'(r1);
    a_rs2        = AW'(r2);
    #1;
    exe_ok = ev && !busy[ea];
    g_exe  = exe_ok && (!lv || last_was_lsu);
    g_lsu  = lv && !g_exe;
    chk("exe_rdy", exe_rdy, g_exe);
    chk("lsu_rdy", lsu_rdy, g_lsu);
    chk("hz_rs1", hz_rs1, hz_model(r1));
    chk("hz_rs2", hz_rs2, hz_model(r2));
    got_exe = exe_rdy;
    pend_en = 1'b0;
    if (g_exe) begin
      last_was_lsu = 1'b0;
      if (ea != 0) begin
        w.a = ea; w.d = ed; exp_q.push_back(w);
        pend_en = 1'b1; pend_a = ea;
      end
    end
    if (g_lsu) begin
      last_was_lsu = 1'b1;
      busy[la] = 1'b0;
      if (la != 0) begin
        w.a = la; w.d = ld; exp_q.push_back(w);
        pend_en = 1'b1; pend_a = la;
      end
    end
    if (iss && (ia != 0)) busy[ia] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned r1, input int unsigned r2);
    step(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  // Monitor: every GPR write the DUT presents must be the oldest expected one.
  initial begin : monitor
    wr_t w;
    forever begin
      @(negedge clk);
      if (e_rd === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: a_rd=%0d d_rd=%0h, expected no write (t=%0t)",
                   a_rd, d_rd, $time);
        end else begin
          w = exp_q.pop_front();
          chk("wr_addr", a_rd, w.a);
          chk("wr_data", d_rd, w.d);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          n_exe;
    int unsigned outs[$];
    bit          ev, iss, lv;
    int unsigned ea, ia, la;
    model_reset();
    #2;

    // Release with both requesters valid: exe first, then lsu.
    do_reset(1, 1, 0);
    step(1, 3, 32'h11, 0, 0, 1, 4, 32'h22, 0, 0);
    step(0, 0, 0,      0, 0, 1, 4, 32'h22, 0, 0);
    idle(0, 0);

    // Outstanding load to x5 blocks exe and flags the hazard until it returns.
    step(0, 0, 0, 1, 5, 0, 0, 0, 5, 0);
    step(1, 5, 32'h55, 0, 0, 0, 0, 0, 5, 0);
    step(1, 5, 32'h55, 0, 0, 0, 0, 0, 5, 0);
    step(1, 5, 32'h55, 0, 0, 1, 5, 32'hA5, 5, 0);
    step(1, 5, 32'h55, 0, 0, 0, 0, 0, 5, 0);
    idle(5, 0);
    idle(5, 0);

    // Issue and return on x7 in the same cycle: the issue wins.
    step(0, 0, 0, 1, 7, 1, 7, 32'h77, 0, 7);
    idle(0, 7);
    idle(0, 7);
    step(0, 0, 0, 0, 0, 1, 7, 32'h78, 0, 7);
    idle(0, 7);

    // Writes to x0 are accepted but never reach the register file.
    step(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_no_write", e_rd, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("x0_iss_ignored_hz", hz_rs1, 0);
    idle(0, 0);

    // Sustained contention: strict alternation, one write every cycle.
    do_reset(0, 0, 0);
    n_exe = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 1 + i, $urandom, 0, 0, 1, 10 + i, $urandom, 0, 0);
      n_exe += int'(got_exe);
      chk("contention_e_rd", e_rd, 1);
    end
    chk("contention_exe_grants", n_exe, 4);
    idle(0, 0);

    // Reset right after a transfer: pending write and loads are dropped.
    step(1, 9, 32'hDEAD_BEEF, 1, 12, 0, 0, 0, 0, 0);
    do_reset(1, 1, 12);
    for (int i = 0; i < 3; i++) begin
      idle(12, 9);
      chk("post_rst_no_write", e_rd, 0);
    end

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      outs.delete();
      for (int a = 1; a < 32; a++) if (busy[a]) outs.push_back(a);
      ev = 1'($urandom_range(0, 1));
      ea = $urandom_range(0, 31);
      lv = (outs.size() > 0) && ($urandom_range(0, 2) != 0);
      la = lv ? outs[$urandom_range(0, outs.size() - 1)] : $urandom_range(0, 31);
      ia = $urandom_range(0, 31);
      iss = ($urandom_range(0, 2) == 0) && !busy[ia];
      step(ev, ea, $urandom, iss, ia, lv, la, $urandom,
           $urandom_range(0, 31), $urandom_range(0, 31));
    end

    idle(0, 0);
    idle(0, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
